// File: rtl/difftest_arch_int_reg_tx.sv
// Difftest integer register-state transmitter: shadow GPR file fed by
// commit writebacks, frozen on request and streamed one register per beat.
module difftest_arch_int_reg_tx #(
   parameter int NR_WB = 2,
   parameter int XLEN  = 64,
   parameter int CNT_W = 16
) (
   input  logic                  io_clock,
   input  logic                  io_reset,
   input  logic [7:0]            io_coreid,
   input  logic [NR_WB-1:0]      io_wb_valid,
   input  logic [5*NR_WB-1:0]    io_wb_addr,
   input  logic [XLEN*NR_WB-1:0] io_wb_data,
   input  logic                  io_snap_req,
   output logic                  io_busy,
   output logic                  io_out_valid,
   input  logic                  io_out_ready,
   output logic [4:0]            io_out_idx,
   output logic [XLEN-1:0]       io_out_data,
   output logic                  io_out_last,
   output logic [7:0]            io_out_coreid,
   output logic [CNT_W-1:0]      io_dropped
);

   typedef enum logic {IDLE, SEND} state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  shadow_q [32];
   logic [XLEN-1:0]  shadow_d [32];
   logic [XLEN-1:0]  buf_q [32];
   logic [4:0]       idx_q, idx_d;
   logic [7:0]       coreid_q, coreid_d;
   logic [CNT_W-1:0] drop_q, drop_d;
   logic             capture;
   logic             fire;

   // Ascending port order lets the highest-numbered port win a collision.
   always_comb begin
      shadow_d = shadow_q;
      for (int k = 0; k < NR_WB; k++) begin
         if (io_wb_valid[k] && (io_wb_addr[5*k +: 5] != 5'd0)) begin
            shadow_d[io_wb_addr[5*k +: 5]] = io_wb_data[XLEN*k +: XLEN];
         end
      end
      shadow_d[0] = '0;
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      coreid_d = coreid_q;
      drop_d   = drop_q;
      capture  = 1'b0;
      fire     = (state_q == SEND) && io_out_ready;
      case (state_q)
         IDLE: begin
            if (io_snap_req) begin
               capture  = 1'b1;
               state_d  = SEND;
               idx_d    = 5'd0;
               coreid_d = io_coreid;
            end
         end
         SEND: begin
            if (io_snap_req && (drop_q != '1)) begin
               drop_d = drop_q + 1'b1;
            end
            if (fire) begin
               if (idx_q == 5'd31) begin
                  state_d = IDLE;
                  idx_d   = 5'd0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge io_clock or posedge io_reset) begin
      if (io_reset) begin
         state_q  <= IDLE;
         idx_q    <= 5'd0;
         coreid_q <= 8'd0;
         drop_q   <= '0;
         for (int i = 0; i < 32; i++) begin
            shadow_q[i] <= '0;
            buf_q[i]    <= '0;
         end
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         coreid_q <= coreid_d;
         drop_q   <= drop_d;
         shadow_q <= shadow_d;
         // Capture the next-state view so same-cycle writebacks land in the snapshot.
         if (capture) begin
            buf_q <= shadow_d;
         end
      end
   end

   assign io_busy       = (state_q == SEND);
   assign io_out_valid  = (state_q == SEND);
   assign io_out_idx    = idx_q;
   assign io_out_data   = (state_q == SEND) ? buf_q[idx_q] : '0;
   assign io_out_last   = (state_q == SEND) && (idx_q == 5'd31);
   assign io_out_coreid = coreid_q;
   assign io_dropped    = drop_q;

endmodule
